fft4_stage_sched: RTL

//  Schedules an in-place radix-4 DIF FFT through one shared pipelined radix-4 butterfly (A..D data, WB/WC/WD twiddles).
//  Per stage: issues one butterfly per cycle (data-RAM read addresses, twiddle-ROM addresses), then writes results back to the same addresses.

---
 rtl/fft4_stage_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/fft4_stage_sched.sv
// Issue/write-back scheduler for an in-place radix-4 DIF FFT.
// Drives a shared pipelined radix-4 butterfly with read, twiddle and write-back addresses.
module fft4_stage_sched #(
  parameter  int LOG4N    = 3,
  parameter  int PIPE_LAT = 4,
  localparam int AW       = 2 * LOG4N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG4N-1:0] stage,
  output logic             rd_en,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [AW-1:0]    rd_addr_c,
  output logic [AW-1:0]    rd_addr_d,
  output logic [AW-1:0]    tw_addr_b,
  output logic [AW-1:0]    tw_addr_c,
  output logic [AW-1:0]    tw_addr_d,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b,
  output logic [AW-1:0]    wr_addr_c,
  output logic [AW-1:0]    wr_addr_d
);

  localparam int               N          = 1 << AW;
  localparam logic [AW-1:0]    K_LAST     = AW'(N / 4 - 1);
  localparam logic [LOG4N-1:0] STAGE_LAST = LOG4N'(LOG4N - 1);
  localparam int               CW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0]    CNT_LAST   = CW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  typedef struct packed {
    logic          vld;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] c;
    logic [AW-1:0] d;
  } pipe_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_k, w_k_nxt;
  logic [LOG4N-1:0] r_stage, w_stage_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_done_nxt;

  logic             r_busy, r_done, r_rd_en;
  logic [AW-1:0]    r_rd_a, r_rd_b, r_rd_c, r_rd_d;
  logic [AW-1:0]    r_tw_b, r_tw_c, r_tw_d;
  pipe_t            r_pipe [PIPE_LAT];

  logic [LOG4N:0]   w_lq;
  logic [LOG4N:0]   w_ts;
  logic [AW-1:0]    w_q, w_j, w_base, w_tw1;

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_stage_nxt = r_stage;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_k_nxt     = '0;
          w_stage_nxt = '0;
        end
      end
      S_ISSUE: begin
        if (r_k == K_LAST) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_k_nxt = r_k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CNT_LAST) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = S_IDLE;
            w_stage_nxt = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_k_nxt     = '0;
            w_stage_nxt = r_stage + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Butterfly span q = 4**(LOG4N-1-stage); base packs group g above the two
  // leg-select bits and j below them, so legs b..d just add multiples of q.
  always_comb begin
    w_lq   = {STAGE_LAST - w_stage_nxt, 1'b0};
    w_ts   = {w_stage_nxt, 1'b0};
    w_q    = AW'(1) << w_lq;
    w_j    = w_k_nxt & (w_q - 1'b1);
    w_base = ((w_k_nxt >> w_lq) << (w_lq + 2'd2)) | w_j;
    w_tw1  = w_j << w_ts;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_stage <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_a  <= '0;
      r_rd_b  <= '0;
      r_rd_c  <= '0;
      r_rd_d  <= '0;
      r_tw_b  <= '0;
      r_tw_c  <= '0;
      r_tw_d  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_stage <= w_stage_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
      if (w_state_nxt == S_ISSUE) begin
        r_rd_en <= 1'b1;
        r_rd_a  <= w_base;
        r_rd_b  <= w_base + w_q;
        r_rd_c  <= w_base + (w_q << 1);
        r_rd_d  <= w_base + (w_q << 1) + w_q;
        r_tw_b  <= w_tw1;
        r_tw_c  <= w_tw1 << 1;
        r_tw_d  <= (w_tw1 << 1) + w_tw1;
      end else begin
        r_rd_en <= 1'b0;
        r_rd_a  <= '0;
        r_rd_b  <= '0;
        r_rd_c  <= '0;
        r_rd_d  <= '0;
        r_tw_b  <= '0;
        r_tw_c  <= '0;
        r_tw_d  <= '0;
      end
    end
  end

  // NOTE: the delay line is reset explicitly: its valid bits must clear so an
  // aborted transform can never emit a late write strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= {r_rd_en, r_rd_a, r_rd_b, r_rd_c, r_rd_d};
      for (int i = 1; i < PIPE_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign stage     = r_stage;
  assign rd_en     = r_rd_en;
  assign rd_addr_a = r_rd_a;
  assign rd_addr_b = r_rd_b;
  assign rd_addr_c = r_rd_c;
  assign rd_addr_d = r_rd_d;
  assign tw_addr_b = r_tw_b;
  assign tw_addr_c = r_tw_c;
  assign tw_addr_d = r_tw_d;
  assign wr_en     = r_pipe[PIPE_LAT-1].vld;
  assign wr_addr_a = r_pipe[PIPE_LAT-1].a;
  assign wr_addr_b = r_pipe[PIPE_LAT-1].b;
  assign wr_addr_c = r_pipe[PIPE_LAT-1].c;
  assign wr_addr_d = r_pipe[PIPE_LAT-1].d;

endmodule
